// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU op/sel codes, bus widths
// and divider state encodings.
package ex_stage_pkg;

  localparam int RegBus     = 32;
  localparam int AluOpBus   = 8;
  localparam int AluSelBus  = 3;
  localparam int RegAddrBus = 5;

  localparam logic [RegBus-1:0] ZeroWord    = '0;
  localparam logic              IsDelaySlot = 1'b1;

  // ALU operation codes
  localparam logic [AluOpBus-1:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [AluOpBus-1:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [AluOpBus-1:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [AluOpBus-1:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [AluOpBus-1:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [AluOpBus-1:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [AluOpBus-1:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [AluOpBus-1:0] EXE_SRA_OP   = 8'b00000011;
  localparam logic [AluOpBus-1:0] EXE_SLT_OP   = 8'b00101010;
  localparam logic [AluOpBus-1:0] EXE_SLTU_OP  = 8'b00101011;
  localparam logic [AluOpBus-1:0] EXE_ADD_OP   = 8'b00100000;
  localparam logic [AluOpBus-1:0] EXE_ADDU_OP  = 8'b00100001;
  localparam logic [AluOpBus-1:0] EXE_SUB_OP   = 8'b00100010;
  localparam logic [AluOpBus-1:0] EXE_SUBU_OP  = 8'b00100011;
  localparam logic [AluOpBus-1:0] EXE_ADDI_OP  = 8'b01010101;
  localparam logic [AluOpBus-1:0] EXE_ADDIU_OP = 8'b01010110;
  localparam logic [AluOpBus-1:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [AluOpBus-1:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [AluOpBus-1:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [AluOpBus-1:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [AluOpBus-1:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [AluOpBus-1:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [AluOpBus-1:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [AluOpBus-1:0] EXE_DIVU_OP  = 8'b00011011;
  localparam logic [AluOpBus-1:0] EXE_JAL_OP   = 8'b01010000;

  // Result classes
  localparam logic [AluSelBus-1:0] EXE_RES_NOP         = 3'b000;
  localparam logic [AluSelBus-1:0] EXE_RES_LOGIC       = 3'b001;
  localparam logic [AluSelBus-1:0] EXE_RES_SHIFT       = 3'b010;
  localparam logic [AluSelBus-1:0] EXE_RES_MOVE        = 3'b011;
  localparam logic [AluSelBus-1:0] EXE_RES_ARITH       = 3'b100;
  localparam logic [AluSelBus-1:0] EXE_RES_MUL         = 3'b101;
  localparam logic [AluSelBus-1:0] EXE_RES_JUMP_BRANCH = 3'b110;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_DBZ  = 2'b01,
    DIV_BUSY = 2'b10,
    DIV_DONE = 2'b11
  } div_state_t;

endpackage

// File: rtl/ex_stage_div.sv
// Sequential restoring divider: one quotient bit per cycle, signed results
// corrected from magnitudes on the way out.
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     dividend_i,
  input  logic [DATA_W-1:0]     divisor_i,
  input  logic                  annul_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic [2*DATA_W-1:0]   result_o
);

  localparam int CNT_W = $clog2(DIV_ITERS);

  div_state_t          r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rem, r_quo, r_div;
  logic                r_negq, r_negr;
  logic [DATA_W:0]     w_shift, w_diff;
  logic                w_ge;

  always_ff @(posedge clk) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DIV_IDLE: if (start_i && !annul_i)
                  w_next = (divisor_i == '0) ? DIV_DBZ : DIV_BUSY;
      DIV_DBZ:  w_next = annul_i ? DIV_IDLE : DIV_DONE;
      DIV_BUSY: begin
        if (annul_i)                           w_next = DIV_IDLE;
        else if (r_cnt == CNT_W'(DIV_ITERS-1)) w_next = DIV_DONE;
      end
      DIV_DONE: w_next = DIV_IDLE;
      default:  w_next = DIV_IDLE;
    endcase
  end

  always_comb begin
    ready_o  = (r_state == DIV_DONE);
    busy_o   = (r_state == DIV_BUSY) || (r_state == DIV_DBZ);
    result_o = {(r_negr ? -r_rem : r_rem), (r_negq ? -r_quo : r_quo)};
  end

  // Quotient register doubles as the dividend shift register.
  assign w_shift = {r_rem, r_quo[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_ge    = (w_shift >= {1'b0, r_div});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: if (start_i && !annul_i) begin
          r_cnt <= '0;
          r_rem <= '0;
          if (divisor_i == '0) begin
            r_quo  <= '0;
            r_div  <= '0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
          end else begin
            r_quo  <= (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
            r_div  <= (signed_i && divisor_i[DATA_W-1])  ? -divisor_i  : divisor_i;
            r_negq <= signed_i && (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
            r_negr <= signed_i && dividend_i[DATA_W-1];
          end
        end
        DIV_BUSY: begin
          r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
          r_quo <= {r_quo[DATA_W-2:0], w_ge};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU, HI/LO moves and multiply, with a
// sequential divider that stalls the pipeline until its result is ready.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AluOpBus-1:0]    aluop_i,
  input  logic [AluSelBus-1:0]   alusel_i,
  input  logic [DATA_W-1:0]      rdata1_i,
  input  logic [DATA_W-1:0]      rdata2_i,
  input  logic [RegAddrBus-1:0]  waddr_reg_i,
  input  logic                   we_reg_i,
  input  logic                   now_in_delayslot_i,
  input  logic [DATA_W-1:0]      return_addr_i,
  input  logic [DATA_W-1:0]      hi_i,
  input  logic [DATA_W-1:0]      lo_i,
  input  logic                   annul_i,
  output logic [RegAddrBus-1:0]  waddr_reg_o,
  output logic                   we_reg_o,
  output logic [DATA_W-1:0]      wdata_o,
  output logic                   whilo_o,
  output logic [DATA_W-1:0]      hi_o,
  output logic [DATA_W-1:0]      lo_o,
  output logic                   in_delayslot_o,
  output logic                   stallreq_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0]   w_logic, w_shift, w_arith, w_move, w_res;
  logic [DATA_W-1:0]   w_b_op, w_sum;
  logic                w_is_sub, w_ov_add, w_ov_sub, w_ov;
  logic [2*DATA_W-1:0] w_prod_s, w_prod_u;
  logic                w_is_div, w_div_ready, w_div_busy;
  logic [2*DATA_W-1:0] w_div_res;
  logic [SH_W-1:0]     w_sa;

  always_comb begin
    w_logic = '0;
    case (aluop_i)
      EXE_AND_OP: w_logic = rdata1_i & rdata2_i;
      EXE_OR_OP:  w_logic = rdata1_i | rdata2_i;
      EXE_XOR_OP: w_logic = rdata1_i ^ rdata2_i;
      EXE_NOR_OP: w_logic = ~(rdata1_i | rdata2_i);
      default:    w_logic = '0;
    endcase
  end

  assign w_sa = rdata1_i[SH_W-1:0];

  always_comb begin
    w_shift = '0;
    case (aluop_i)
      EXE_SLL_OP: w_shift = rdata2_i << w_sa;
      EXE_SRL_OP: w_shift = rdata2_i >> w_sa;
      EXE_SRA_OP: w_shift = $signed(rdata2_i) >>> w_sa;
      default:    w_shift = '0;
    endcase
  end

  assign w_is_sub = (aluop_i == EXE_SUB_OP) || (aluop_i == EXE_SUBU_OP);
  assign w_b_op   = w_is_sub ? -rdata2_i : rdata2_i;
  assign w_sum    = rdata1_i + w_b_op;
  // Overflow judged on the original operands so SUB of the most negative value is right.
  assign w_ov_add = (rdata1_i[DATA_W-1] == rdata2_i[DATA_W-1]) &&
                    (w_sum[DATA_W-1] != rdata1_i[DATA_W-1]);
  assign w_ov_sub = (rdata1_i[DATA_W-1] != rdata2_i[DATA_W-1]) &&
                    (w_sum[DATA_W-1] != rdata1_i[DATA_W-1]);
  assign w_ov     = ((aluop_i == EXE_ADD_OP) || (aluop_i == EXE_ADDI_OP)) ? w_ov_add :
                    (aluop_i == EXE_SUB_OP) ? w_ov_sub : 1'b0;

  always_comb begin
    w_arith = '0;
    case (aluop_i)
      EXE_SLT_OP:  w_arith = {{(DATA_W-1){1'b0}}, ($signed(rdata1_i) < $signed(rdata2_i))};
      EXE_SLTU_OP: w_arith = {{(DATA_W-1){1'b0}}, (rdata1_i < rdata2_i)};
      EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP,
      EXE_SUB_OP, EXE_SUBU_OP: w_arith = w_sum;
      default:     w_arith = '0;
    endcase
  end

  always_comb begin
    w_move = '0;
    case (aluop_i)
      EXE_MFHI_OP: w_move = hi_i;
      EXE_MFLO_OP: w_move = lo_i;
      default:     w_move = '0;
    endcase
  end

  always_comb begin
    w_res = '0;
    case (alusel_i)
      EXE_RES_LOGIC:       w_res = w_logic;
      EXE_RES_SHIFT:       w_res = w_shift;
      EXE_RES_ARITH:       w_res = w_arith;
      EXE_RES_MOVE:        w_res = w_move;
      EXE_RES_JUMP_BRANCH: w_res = return_addr_i;
      default:             w_res = '0;
    endcase
  end

  assign w_prod_s = {{DATA_W{rdata1_i[DATA_W-1]}}, rdata1_i} *
                    {{DATA_W{rdata2_i[DATA_W-1]}}, rdata2_i};
  assign w_prod_u = {{DATA_W{1'b0}}, rdata1_i} * {{DATA_W{1'b0}}, rdata2_i};

  assign w_is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

  div_unit #(.DATA_W(DATA_W), .DIV_ITERS(DIV_ITERS)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (w_is_div),
    .signed_i   (aluop_i == EXE_DIV_OP),
    .dividend_i (rdata1_i),
    .divisor_i  (rdata2_i),
    .annul_i    (annul_i),
    .ready_o    (w_div_ready),
    .busy_o     (w_div_busy),
    .result_o   (w_div_res)
  );

  always_comb begin
    waddr_reg_o    = '0;
    we_reg_o       = 1'b0;
    wdata_o        = '0;
    in_delayslot_o = 1'b0;
    whilo_o        = 1'b0;
    hi_o           = '0;
    lo_o           = '0;
    stallreq_o     = 1'b0;
    if (!rst) begin
      waddr_reg_o    = waddr_reg_i;
      we_reg_o       = we_reg_i && !w_ov;
      wdata_o        = w_res;
      in_delayslot_o = now_in_delayslot_i;
      stallreq_o     = w_div_busy || (w_is_div && !w_div_ready);
      if (w_div_ready) begin
        whilo_o = 1'b1;
        hi_o    = w_div_res[2*DATA_W-1:DATA_W];
        lo_o    = w_div_res[DATA_W-1:0];
      end else begin
        case (aluop_i)
          EXE_MTHI_OP:  begin whilo_o = 1'b1; hi_o = rdata1_i; lo_o = lo_i; end
          EXE_MTLO_OP:  begin whilo_o = 1'b1; hi_o = hi_i; lo_o = rdata1_i; end
          EXE_MULT_OP:  begin
            whilo_o = 1'b1;
            hi_o = w_prod_s[2*DATA_W-1:DATA_W];
            lo_o = w_prod_s[DATA_W-1:0];
          end
          EXE_MULTU_OP: begin
            whilo_o = 1'b1;
            hi_o = w_prod_u[2*DATA_W-1:DATA_W];
            lo_o = w_prod_u[DATA_W-1:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] rdata1_i, rdata2_i, return_addr_i, hi_i, lo_i;
  logic [4:0]  waddr_reg_i;
  logic        we_reg_i, now_in_delayslot_i, annul_i;
  logic [4:0]  waddr_reg_o;
  logic        we_reg_o, whilo_o, in_delayslot_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk                (clk),
    .rst                (rst),
    .aluop_i            (aluop_i),
    .alusel_i           (alusel_i),
    .rdata1_i           (rdata1_i),
    .rdata2_i           (rdata2_i),
    .waddr_reg_i        (waddr_reg_i),
    .we_reg_i           (we_reg_i),
    .now_in_delayslot_i (now_in_delayslot_i),
    .return_addr_i      (return_addr_i),
    .hi_i               (hi_i),
    .lo_i               (lo_i),
    .annul_i            (annul_i),
    .waddr_reg_o        (waddr_reg_o),
    .we_reg_o           (we_reg_o),
    .wdata_o            (wdata_o),
    .whilo_o            (whilo_o),
    .hi_o               (hi_o),
    .lo_o               (lo_o),
    .in_delayslot_o     (in_delayslot_o),
    .stallreq_o         (stallreq_o)
  );

  typedef struct {
    string       nm;
    int          cyc;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ds;
    logic        stall;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.nm, e.cyc, cyc);
      end else if ({waddr_reg_o, we_reg_o, wdata_o, whilo_o, hi_o, lo_o, in_delayslot_o, stallreq_o} !==
                   {e.waddr, e.we, e.wdata, e.whilo, e.hi, e.lo, e.ds, e.stall}) begin
        n_bad++;
        $display("FAIL %s @%0d: got wa=%0d we=%b wd=%h whilo=%b hi=%h lo=%h ds=%b st=%b, want wa=%0d we=%b wd=%h whilo=%b hi=%h lo=%h ds=%b st=%b",
                 e.nm, cyc, waddr_reg_o, we_reg_o, wdata_o, whilo_o, hi_o, lo_o, in_delayslot_o, stallreq_o,
                 e.waddr, e.we, e.wdata, e.whilo, e.hi, e.lo, e.ds, e.stall);
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic we, input logic [4:0] wa,
                       input logic ds, input logic [31:0] ra);
    aluop_i = op; alusel_i = sel; rdata1_i = a; rdata2_i = b;
    we_reg_i = we; waddr_reg_i = wa; now_in_delayslot_i = ds; return_addr_i = ra;
  endtask

  task automatic expect_out(input string nm, input logic [4:0] wa, input logic we,
                            input logic [31:0] wd, input logic whilo, input logic [31:0] hi,
                            input logic [31:0] lo, input logic ds, input logic st);
    exp_t e;
    e.nm = nm; e.cyc = cyc; e.waddr = wa; e.we = we; e.wdata = wd; e.whilo = whilo;
    e.hi = hi; e.lo = lo; e.ds = ds; e.stall = st;
    sb.push_back(e);
  endtask

  task automatic expect_zero(input string nm);
    expect_out(nm, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic expect_stall(input string nm);
    expect_out(nm, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  // Divide issued at cycle 0, held until the result cycle, then replaced by a NOP.
  task automatic run_div(input string nm, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int stalls);
    next_cyc();
    drive(op, EXE_RES_NOP, a, b, 1'b0, 5'd0, 1'b0, 32'h0);
    expect_stall({nm, "_stall"});
    for (int i = 1; i < stalls; i++) begin
      next_cyc();
      expect_stall({nm, "_stall"});
    end
    next_cyc();
    expect_out({nm, "_done"}, 5'd0, 1'b0, 32'h0, 1'b1, ehi, elo, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
    expect_zero({nm, "_after"});
  endtask

  // DIVU 100/7 aborted at cnt=10 by annul or reset; no HI/LO write may follow.
  task automatic run_abort(input string nm, input logic use_rst);
    next_cyc();
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 1'b0, 5'd0, 1'b0, 32'h0);
    expect_stall({nm, "_stall"});
    for (int i = 1; i <= 10; i++) begin
      next_cyc();
      expect_stall({nm, "_stall"});
    end
    next_cyc();
    if (use_rst) begin
      rst = 1'b1;
      expect_zero({nm, "_rst"});
    end else begin
      annul_i = 1'b1;
      expect_stall({nm, "_annul"});
    end
    next_cyc();
    rst = 1'b0;
    annul_i = 1'b0;
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
    expect_zero({nm, "_idle"});
    for (int i = 0; i < 30; i++) begin
      next_cyc();
      expect_zero({nm, "_nohilo"});
    end
  endtask

  initial begin
    rst = 1'b1;
    annul_i = 1'b0;
    hi_i = 32'hAAAA_0001;
    lo_i = 32'h5555_0002;
    drive(EXE_ADDU_OP, EXE_RES_ARITH, 32'h1, 32'h2, 1'b1, 5'd5, 1'b1, 32'h44);

    next_cyc(); expect_zero("reset0");
    next_cyc(); expect_zero("reset1");
    next_cyc(); rst = 1'b0;

    drive(EXE_ADD_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd3, 1'b0, 32'h0);
    expect_out("add_ovf", 5'd3, 1'b0, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_ADDU_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd3, 1'b0, 32'h0);
    expect_out("addu", 5'd3, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_SUB_OP, EXE_RES_ARITH, 32'h8000_0000, 32'h1, 1'b1, 5'd4, 1'b0, 32'h0);
    expect_out("sub_ovf", 5'd4, 1'b0, 32'h7FFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_SUBU_OP, EXE_RES_ARITH, 32'h5, 32'h7, 1'b1, 5'd4, 1'b0, 32'h0);
    expect_out("subu", 5'd4, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 1'b1, 5'd6, 1'b0, 32'h0);
    expect_out("sra", 5'd6, 1'b1, 32'hF800_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 1'b1, 5'd6, 1'b0, 32'h0);
    expect_out("srl", 5'd6, 1'b1, 32'h0800_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_SLL_OP, EXE_RES_SHIFT, 32'h0000_0024, 32'h0000_00F1, 1'b1, 5'd6, 1'b0, 32'h0);
    expect_out("sll", 5'd6, 1'b1, 32'h0000_0F10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h1, 1'b1, 5'd7, 1'b0, 32'h0);
    expect_out("slt", 5'd7, 1'b1, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h1, 1'b1, 5'd7, 1'b0, 32'h0);
    expect_out("sltu", 5'd7, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1, 5'd8, 1'b0, 32'h0);
    expect_out("and", 5'd8, 1'b1, 32'h00F0_000F, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_OR_OP, EXE_RES_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1, 5'd8, 1'b0, 32'h0);
    expect_out("or", 5'd8, 1'b1, 32'hFFF0_0FFF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_XOR_OP, EXE_RES_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1, 5'd8, 1'b0, 32'h0);
    expect_out("xor", 5'd8, 1'b1, 32'hFF00_0FF0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_NOR_OP, EXE_RES_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1, 5'd8, 1'b0, 32'h0);
    expect_out("nor", 5'd8, 1'b1, 32'h000F_F000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFE, 32'h3, 1'b0, 5'd0, 1'b0, 32'h0);
    expect_out("mult", 5'd0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'h2, 1'b0, 5'd0, 1'b0, 32'h0);
    expect_out("multu", 5'd0, 1'b0, 32'h0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_MTHI_OP, EXE_RES_NOP, 32'h1234_5678, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
    expect_out("mthi", 5'd0, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 32'h5555_0002, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_MTLO_OP, EXE_RES_NOP, 32'h1234_5678, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
    expect_out("mtlo", 5'd0, 1'b0, 32'h0, 1'b1, 32'hAAAA_0001, 32'h1234_5678, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 1'b1, 5'd9, 1'b0, 32'h0);
    expect_out("mfhi", 5'd9, 1'b1, 32'hAAAA_0001, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 1'b1, 5'd9, 1'b0, 32'h0);
    expect_out("mflo", 5'd9, 1'b1, 32'h5555_0002, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(EXE_JAL_OP, EXE_RES_JUMP_BRANCH, 32'h0, 32'h0, 1'b1, 5'd31, 1'b1, 32'h0000_0108);
    expect_out("jal", 5'd31, 1'b1, 32'h0000_0108, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    run_div("div_m7_2",  EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_div("div_7_m2",  EXE_DIV_OP,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
    run_div("divu_100_7", EXE_DIVU_OP, 32'd100,      32'd7,        32'h0000_0002, 32'h0000_000E, 33);
    run_div("divu_dbz",  EXE_DIVU_OP, 32'd7,         32'd0,        32'h0,         32'h0,         2);
    run_abort("annul", 1'b0);
    run_abort("rstabort", 1'b1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) next_cyc();
    while (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation never checked (cycle %0d)", sb[0].nm, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; consumes the registered ID/EX outputs and produces the register-writeback and HI/LO-writeback payloads for the EX/MEM register.
- Single-cycle logic, shift, arithmetic, move, multiply and link operations.
- DIV/DIVU run on a 32-iteration sequential divider that stalls the pipeline through `stallreq_o`.

Parameters:
- DATA_W, 32, register/data width.
- DIV_ITERS, 32, divider iterations; must equal DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- aluop_i  in  8  operation code (`AluOpBus`)
- alusel_i  in  3  result class (`AluSelBus`): logic/shift/arith/move/jump-link/nop
- rdata1_i  in  32  operand 1; also shift amount in [4:0]
- rdata2_i  in  32  operand 2; also shift value
- waddr_reg_i  in  5  destination register
- we_reg_i  in  1  register write enable
- now_in_delayslot_i  in  1  instruction is in a delay slot
- return_addr_i  in  32  link address for JAL/JALR/BxxAL
- hi_i  in  32  current HI, already forwarded upstream
- lo_i  in  32  current LO, already forwarded upstream
- annul_i  in  1  flush; aborts an in-flight divide
- waddr_reg_o  out  5  destination register
- we_reg_o  out  1  register write enable
- wdata_o  out  32  register write data
- whilo_o  out  1  HI/LO write enable
- hi_o  out  32  HI write data
- lo_o  out  32  LO write data
- in_delayslot_o  out  1  pass-through of `now_in_delayslot_i`
- stallreq_o  out  1  stall request to pipeline control

Behaviour:
Reset and pass-through
- While rst=1, all outputs are forced to 0 combinationally.
- On rst the divider FSM goes to IDLE; counter, partial remainder and quotient clear to 0.
- `waddr_reg_o` and `in_delayslot_o` pass through unchanged.
- `we_reg_o = we_reg_i`, except it is 0 on signed overflow of ADD/ADDI/SUB.

Single-cycle result select (by `alusel_i`)
- logic: AND/OR/XOR/NOR/LUI-as-OR.
- shift: SLL/SRL/SRA of rdata2 by rdata1[4:0].
- arith: ADD/ADDU/SUB/SUBU/SLT/SLTU; all arithmetic is mod 2^32; SLT compares signed, SLTU unsigned.
- move: MFHI → `hi_i`, MFLO → `lo_i`.
- jump-link: `return_addr_i`.
- nop: 0.

HI/LO writes
- MTHI: whilo=1, hi_o=rdata1, lo_o=lo_i.
- MTLO: whilo=1, hi_o=hi_i, lo_o=rdata1.
- MULT/MULTU: 64-bit signed/unsigned product, same cycle; {hi_o,lo_o}=product, whilo=1.
- All other non-divide ops: whilo=0.

Divider FSM: IDLE, DBZ, BUSY, DONE
- IDLE: on DIV/DIVU with annul_i=0, go to DBZ if rdata2=0, else BUSY.
  - On entry to BUSY: latch |a| and |b| (raw values for DIVU) and the signs; cnt=0.
- BUSY: one restoring step per cycle; cnt++.
  - After the step with cnt=DIV_ITERS-1, go to DONE.
- DBZ: result quotient=0, remainder=0; go to DONE next cycle.
- DONE: present the result; go to IDLE unconditionally next cycle, so back-to-back divides each restart.
- Signed result correction: quotient negated if sign(a)^sign(b); remainder takes the sign of a. DIVU uses no correction.
- Output mapping in DONE: lo_o=quotient, hi_o=remainder, whilo=1.
- stallreq_o=1 for a divide op in IDLE, and in DBZ and BUSY; 0 in DONE and otherwise.
- Latency: divide seen at cycle 0 → result in cycle 33, 33 stall cycles. Divide by zero → result in cycle 2.
- annul_i=1 in BUSY or DBZ → IDLE next cycle, no whilo, stallreq drops next cycle.
- rst in any state → IDLE next edge.

Decomposition:
- Shared package (defines): ALU op and sel codes, `ZeroWord`, `RegBus`/`AluOpBus`/`AluSelBus`/`RegAddrBus` widths, `IsDelaySlot`, divider state encodings.
- Sub-module `div_unit`: divider FSM and datapath.
  - Inputs: start, signed, dividend, divisor, annul.
  - Outputs: ready, result[63:0].

Test Plan:
- ADD rdata1=0x7FFFFFFF, rdata2=1, we_reg_i=1 → we_reg_o=0. ADDU with the same operands → wdata=0x80000000, we_reg_o=1.
- SRA rdata1=4, rdata2=0x80000000 → wdata=0xF8000000. SLT with (-1, 1) → 1. SLTU with (-1, 1) → 0.
- MULT with (-2, 3) → hi=0xFFFFFFFF, lo=0xFFFFFFFA, whilo=1, no stall.
- DIV with (-7, 2) → stallreq high exactly 33 cycles; in DONE lo=0xFFFFFFFD, hi=0xFFFFFFFF, whilo=1. DIVU with (7, 0) → stall 2 cycles, hi=lo=0.
- DIVU in BUSY at cnt=10 with annul_i pulsed → IDLE next cycle, whilo never asserted. Repeat the divide with rst instead of annul → same outcome.
- JAL alusel with return_addr_i=0x00000108, waddr=31, delay slot=1 → wdata=0x108, we=1, in_delayslot_o=1.
